// File: rtl/id_exe_stage_reg_pkg.sv
// Shared widths for the ID/EXE boundary and the packed control bundle layout.
// Control bundle order, MSB first: {exe_cmd, mem_read, mem_write, wb_enable, branch_taken, status_write_enable}.
package id_exe_stage_reg_pkg;

  localparam int unsigned WORD_LEN            = 32;
  localparam int unsigned REG_ADDR_LEN        = 4;
  localparam int unsigned EXECUTE_COMMAND_LEN = 4;
  localparam int unsigned CTRL_FLAG_BITS      = 5;
  localparam int unsigned CTRL_BUNDLE_LEN     = EXECUTE_COMMAND_LEN + CTRL_FLAG_BITS;
  localparam int unsigned SHIFT_OPERAND_LEN   = 12;
  localparam int unsigned SIGNED_IMM_LEN      = 24;

  // pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, src1, src2, carry
  function automatic int unsigned data_bundle_len(input int unsigned word_len,
                                                  input int unsigned reg_addr_len);
    return 3 * word_len + 3 * reg_addr_len + 2 + SHIFT_OPERAND_LEN + SIGNED_IMM_LEN;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Parameterised pipeline register: synchronous reset, load enable and synchronous clear.
// Reset beats everything; a deasserted enable holds even when clear is asserted.
module pipe_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (en_i) begin
      if (clr_i) q_q <= '0;
      else       q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with freeze, flush, bubble and a valid bit.
// Data fields always follow ID when not frozen; control and valid are zeroed on flush, bubble or invalid slots.
module id_exe_stage_reg #(
  parameter int unsigned WORD_LEN     = 32,
  parameter int unsigned REG_ADDR_LEN = 4,
  parameter int unsigned EXE_CMD_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    flush,
  input  logic                    bubble,
  input  logic                    id_valid,
  input  logic [WORD_LEN-1:0]     id_pc,
  input  logic [EXE_CMD_LEN-1:0]  id_exe_cmd,
  input  logic                    id_mem_read,
  input  logic                    id_mem_write,
  input  logic                    id_wb_enable,
  input  logic                    id_branch_taken,
  input  logic                    id_status_write_enable,
  input  logic [WORD_LEN-1:0]     id_val_rn,
  input  logic [WORD_LEN-1:0]     id_val_rm,
  input  logic                    id_imm,
  input  logic [11:0]             id_shift_operand,
  input  logic [23:0]             id_signed_imm_24,
  input  logic [REG_ADDR_LEN-1:0] id_dest,
  input  logic [REG_ADDR_LEN-1:0] id_src1,
  input  logic [REG_ADDR_LEN-1:0] id_src2,
  input  logic                    id_carry,
  output logic                    exe_valid,
  output logic [WORD_LEN-1:0]     exe_pc,
  output logic [EXE_CMD_LEN-1:0]  exe_exe_cmd,
  output logic                    exe_mem_read,
  output logic                    exe_mem_write,
  output logic                    exe_wb_enable,
  output logic                    exe_branch_taken,
  output logic                    exe_status_write_enable,
  output logic [WORD_LEN-1:0]     exe_val_rn,
  output logic [WORD_LEN-1:0]     exe_val_rm,
  output logic                    exe_imm,
  output logic [11:0]             exe_shift_operand,
  output logic [23:0]             exe_signed_imm_24,
  output logic [REG_ADDR_LEN-1:0] exe_dest,
  output logic [REG_ADDR_LEN-1:0] exe_src1,
  output logic [REG_ADDR_LEN-1:0] exe_src2,
  output logic                    exe_carry
);

  import id_exe_stage_reg_pkg::*;

  localparam int unsigned CTRL_W = EXE_CMD_LEN + CTRL_FLAG_BITS + 1;
  localparam int unsigned DATA_W = data_bundle_len(WORD_LEN, REG_ADDR_LEN);

  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              ctrl_clr;

  assign ctrl_d = {id_valid, id_exe_cmd, id_mem_read, id_mem_write,
                   id_wb_enable, id_branch_taken, id_status_write_enable};
  assign data_d = {id_pc, id_val_rn, id_val_rm, id_imm, id_shift_operand,
                   id_signed_imm_24, id_dest, id_src1, id_src2, id_carry};

  // Invalid slots are cleared too, so no side effect can escape from a non-instruction.
  assign ctrl_clr = flush | bubble | ~id_valid;

  pipe_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
    .clk   (clk),
    .rst   (rst),
    .en_i  (~freeze),
    .clr_i (ctrl_clr),
    .d_i   (ctrl_d),
    .q_o   (ctrl_q)
  );

  pipe_reg #(.WIDTH(DATA_W)) u_data_reg (
    .clk   (clk),
    .rst   (rst),
    .en_i  (~freeze),
    .clr_i (1'b0),
    .d_i   (data_d),
    .q_o   (data_q)
  );

  assign {exe_valid, exe_exe_cmd, exe_mem_read, exe_mem_write,
          exe_wb_enable, exe_branch_taken, exe_status_write_enable} = ctrl_q;
  assign {exe_pc, exe_val_rn, exe_val_rm, exe_imm, exe_shift_operand,
          exe_signed_imm_24, exe_dest, exe_src1, exe_src2, exe_carry} = data_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Scoreboard bench for id_exe_stage_reg: a behavioural model pushes the expected
// exe_* bundle at each drive, and it is popped and compared one edge later.
module tb_id_exe_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cmd;
    logic        mr, mw, wb, br, sw;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dest, s1, s2;
    logic        carry;
  } out_t;

  logic clk = 1'b0;
  logic rst, freeze, flush, bubble, id_valid;
  logic [31:0] id_pc, id_val_rn, id_val_rm;
  logic [3:0]  id_exe_cmd, id_dest, id_src1, id_src2;
  logic id_mem_read, id_mem_write, id_wb_enable, id_branch_taken, id_status_write_enable;
  logic id_imm, id_carry;
  logic [11:0] id_shift_operand;
  logic [23:0] id_signed_imm_24;

  logic exe_valid, exe_mem_read, exe_mem_write, exe_wb_enable, exe_branch_taken;
  logic exe_status_write_enable, exe_imm, exe_carry;
  logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
  logic [3:0]  exe_exe_cmd, exe_dest, exe_src1, exe_src2;
  logic [11:0] exe_shift_operand;
  logic [23:0] exe_signed_imm_24;

  int unsigned total = 0;
  int unsigned bad   = 0;
  out_t mdl = '0;
  out_t expq[$];

  always #5 clk = ~clk;

  id_exe_stage_reg #(.WORD_LEN(32), .REG_ADDR_LEN(4), .EXE_CMD_LEN(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble(bubble),
    .id_valid(id_valid), .id_pc(id_pc), .id_exe_cmd(id_exe_cmd),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_wb_enable(id_wb_enable),
    .id_branch_taken(id_branch_taken), .id_status_write_enable(id_status_write_enable),
    .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_imm(id_imm),
    .id_shift_operand(id_shift_operand), .id_signed_imm_24(id_signed_imm_24),
    .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2), .id_carry(id_carry),
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_exe_cmd(exe_exe_cmd),
    .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write), .exe_wb_enable(exe_wb_enable),
    .exe_branch_taken(exe_branch_taken), .exe_status_write_enable(exe_status_write_enable),
    .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm), .exe_imm(exe_imm),
    .exe_shift_operand(exe_shift_operand), .exe_signed_imm_24(exe_signed_imm_24),
    .exe_dest(exe_dest), .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_carry(exe_carry)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] cmd, input logic mr, input logic mw,
                        input logic wb, input logic br, input logic sw,
                        input logic [31:0] pc, input logic [31:0] rn, input logic [3:0] dest);
    id_valid = v; id_exe_cmd = cmd; id_mem_read = mr; id_mem_write = mw;
    id_wb_enable = wb; id_branch_taken = br; id_status_write_enable = sw;
    id_pc = pc; id_val_rn = rn; id_dest = dest;
    id_val_rm = $urandom; id_imm = 1'($urandom); id_shift_operand = 12'($urandom);
    id_signed_imm_24 = 24'($urandom); id_src1 = 4'($urandom); id_src2 = 4'($urandom);
    id_carry = 1'($urandom);
  endtask

  task automatic set_flags(input logic r, input logic fz, input logic fl, input logic bb);
    rst = r; freeze = fz; flush = fl; bubble = bb;
  endtask

  // Predict the register contents after the coming edge, then compare after it.
  task automatic step();
    out_t nx, e;
    logic live;
    if (rst) nx = '0;
    else if (freeze) nx = mdl;
    else begin
      live = id_valid && !flush && !bubble;
      nx.valid = live;
      nx.cmd = live ? id_exe_cmd : 4'h0;
      nx.mr = live && id_mem_read;
      nx.mw = live && id_mem_write;
      nx.wb = live && id_wb_enable;
      nx.br = live && id_branch_taken;
      nx.sw = live && id_status_write_enable;
      nx.pc = id_pc; nx.rn = id_val_rn; nx.rm = id_val_rm; nx.imm = id_imm;
      nx.sh = id_shift_operand; nx.simm = id_signed_imm_24; nx.dest = id_dest;
      nx.s1 = id_src1; nx.s2 = id_src2; nx.carry = id_carry;
    end
    mdl = nx;
    expq.push_back(nx);
    @(posedge clk);
    #1;
    if (expq.size() == 0) begin
      check("sb_underflow", 64'd0, 64'd1);
    end else begin
      e = expq.pop_front();
      check("valid", 64'(exe_valid), 64'(e.valid));
      check("cmd",   64'(exe_exe_cmd), 64'(e.cmd));
      check("mem_read", 64'(exe_mem_read), 64'(e.mr));
      check("mem_write", 64'(exe_mem_write), 64'(e.mw));
      check("wb_enable", 64'(exe_wb_enable), 64'(e.wb));
      check("branch_taken", 64'(exe_branch_taken), 64'(e.br));
      check("status_we", 64'(exe_status_write_enable), 64'(e.sw));
      check("pc", 64'(exe_pc), 64'(e.pc));
      check("val_rn", 64'(exe_val_rn), 64'(e.rn));
      check("val_rm", 64'(exe_val_rm), 64'(e.rm));
      check("imm", 64'(exe_imm), 64'(e.imm));
      check("shift_op", 64'(exe_shift_operand), 64'(e.sh));
      check("simm24", 64'(exe_signed_imm_24), 64'(e.simm));
      check("dest", 64'(exe_dest), 64'(e.dest));
      check("src1", 64'(exe_src1), 64'(e.s1));
      check("src2", 64'(exe_src2), 64'(e.s2));
      check("carry", 64'(exe_carry), 64'(e.carry));
    end
  endtask

  initial begin
    // Reset with every ID input at all-ones
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b1; id_pc = '1; id_exe_cmd = '1; id_mem_read = 1'b1; id_mem_write = 1'b1;
    id_wb_enable = 1'b1; id_branch_taken = 1'b1; id_status_write_enable = 1'b1;
    id_val_rn = '1; id_val_rm = '1; id_imm = 1'b1; id_shift_operand = '1;
    id_signed_imm_24 = '1; id_dest = '1; id_src1 = '1; id_src2 = '1; id_carry = 1'b1;
    step();
    step();
    check("rst_valid", 64'(exe_valid), 64'd0);
    check("rst_pc", 64'(exe_pc), 64'd0);
    check("rst_ctrl", 64'({exe_exe_cmd, exe_mem_read, exe_mem_write, exe_wb_enable}), 64'd0);

    // ADD
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    set_id(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h5, 4'd3);
    step();
    check("add_cmd", 64'(exe_exe_cmd), 64'h2);
    check("add_wb", 64'(exe_wb_enable), 64'd1);
    check("add_rn", 64'(exe_val_rn), 64'h5);
    check("add_dest", 64'(exe_dest), 64'd3);
    check("add_valid", 64'(exe_valid), 64'd1);

    // Freeze for 3 cycles while ID shows LDR and flush/bubble pulse
    set_id(1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h99, 4'd7);
    set_flags(1'b0, 1'b1, 1'b1, 1'b0); step();
    set_flags(1'b0, 1'b1, 1'b0, 1'b1); step();
    set_flags(1'b0, 1'b1, 1'b1, 1'b1); step();
    check("frz_rn", 64'(exe_val_rn), 64'h5);
    check("frz_mem_read", 64'(exe_mem_read), 64'd0);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0); step();
    check("ldr_mem_read", 64'(exe_mem_read), 64'd1);
    check("ldr_dest", 64'(exe_dest), 64'd7);

    // Flush with STR in ID
    set_id(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h7, 4'd2);
    set_flags(1'b0, 1'b0, 1'b1, 1'b0); step();
    check("fl_mem_write", 64'(exe_mem_write), 64'd0);
    check("fl_valid", 64'(exe_valid), 64'd0);
    check("fl_cmd", 64'(exe_exe_cmd), 64'd0);
    check("fl_pc", 64'(exe_pc), 64'h40);

    // Bubble with CMP, then capture it
    set_id(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h1, 4'd0);
    set_flags(1'b0, 1'b0, 1'b0, 1'b1); step();
    check("bb_sw", 64'(exe_status_write_enable), 64'd0);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0); step();
    check("cmp_sw", 64'(exe_status_write_enable), 64'd1);

    // Invalid slot with write-enables set
    set_id(1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h48, 32'h2, 4'd9);
    step();
    check("inv_wb", 64'(exe_wb_enable), 64'd0);
    check("inv_mw", 64'(exe_mem_write), 64'd0);
    check("inv_valid", 64'(exe_valid), 64'd0);

    // Valid instruction, then reset while frozen
    set_id(1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4c, 32'h3, 4'd5);
    step();
    set_flags(1'b1, 1'b1, 1'b0, 1'b0); step();
    check("rstfrz_valid", 64'(exe_valid), 64'd0);
    check("rstfrz_pc", 64'(exe_pc), 64'd0);

    // Randomised mix of all controls
    for (int i = 0; i < 200; i++) begin
      set_id(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
      set_flags(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
